// File: rtl/serial_word_assembler.sv
// serial_word_assembler: deserialises a framed, LSB-first bitstream into
// WIDTH-bit words and hands them out through a two-entry valid/ready buffer.
module serial_word_assembler #(
   parameter int WIDTH        = 16,
   parameter bit REQUIRE_SYNC = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     bit_in,
   input  logic                     bit_valid,
   input  logic                     sync,
   input  logic                     clear_ovf,
   output logic [WIDTH-1:0]         word_out,
   output logic                     word_valid,
   input  logic                     word_ready,
   output logic                     overflow,
   output logic [$clog2(WIDTH)-1:0] bit_count,
   output logic                     in_frame
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   localparam state_t RST_STATE = REQUIRE_SYNC ? IDLE : RECV;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    bcnt, bcnt_nxt;
   logic [CW-1:0]    base_cnt;
   logic             accept;
   logic             complete;
   logic [WIDTH-1:0] word_new;

   logic [WIDTH-1:0] head, head_nxt;
   logic [WIDTH-1:0] skid, skid_nxt;
   logic [1:0]       cnt, cnt_nxt;
   logic             pop;
   logic             drop;
   logic             ovf_nxt;

   // Word being completed if the current bit is the last one of the frame.
   assign word_new = {bit_in, shreg[WIDTH-1:1]};

   // Receiver FSM: frame tracking, shift register and bit counter.
   // Stale shreg bits left after a re-sync need no clearing: a full word of
   // shifts overwrites every position before the word is pushed.
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      bcnt_nxt  = bcnt;
      complete  = 1'b0;
      accept    = bit_valid && (sync || (state == RECV));
      base_cnt  = sync ? '0 : bcnt;
      if (sync) begin
         state_nxt = RECV;
         bcnt_nxt  = '0;
      end
      if (accept) begin
         shreg_nxt = word_new;
         if (base_cnt == LAST) begin
            complete = 1'b1;
            bcnt_nxt = '0;
         end else begin
            bcnt_nxt = base_cnt + CW'(1);
         end
      end
   end

   // Receiver state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RST_STATE;
         shreg <= '0;
         bcnt  <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         bcnt  <= bcnt_nxt;
      end
   end

   assign pop = (cnt != 2'd0) && word_ready;

   // Output buffer update: a pop frees its slot before a concurrent push lands.
   always_comb begin
      head_nxt = head;
      skid_nxt = skid;
      cnt_nxt  = cnt;
      drop     = 1'b0;
      if (pop && complete) begin
         if (cnt == 2'd2) begin
            head_nxt = skid;
            skid_nxt = word_new;
         end else begin
            head_nxt = word_new;
         end
      end else if (complete) begin
         case (cnt)
            2'd0: begin
               head_nxt = word_new;
               cnt_nxt  = 2'd1;
            end
            2'd1: begin
               skid_nxt = word_new;
               cnt_nxt  = 2'd2;
            end
            default: drop = 1'b1;
         endcase
      end else if (pop) begin
         if (cnt == 2'd2) begin
            head_nxt = skid;
            skid_nxt = '0;
            cnt_nxt  = 2'd1;
         end else begin
            head_nxt = '0;
            cnt_nxt  = 2'd0;
         end
      end
      ovf_nxt = drop ? 1'b1 : (clear_ovf ? 1'b0 : overflow);
   end

   // Output buffer and sticky overflow registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head     <= '0;
         skid     <= '0;
         cnt      <= 2'd0;
         overflow <= 1'b0;
      end else begin
         head     <= head_nxt;
         skid     <= skid_nxt;
         cnt      <= cnt_nxt;
         overflow <= ovf_nxt;
      end
   end

   assign word_out   = head;
   assign word_valid = (cnt != 2'd0);
   assign bit_count  = bcnt;
   assign in_frame   = (state == RECV);

endmodule
